// File: rtl/reorder_buffer_mt.sv
`default_nettype none
// reorder_buffer_mt: per-thread in-order ROB with out-of-order writeback, round-robin retire and exception flush.
// Optional macro ROB_WB_BYPASS_EN: the bypass lookup also forwards same-cycle writeback data.
module reorder_buffer_mt #(
    parameter int THREADS  = 4,
    parameter int ENTRIES  = 8,
    parameter int WB_PORTS = 3,
    parameter int DATA_W   = 32,
    parameter int DEST_W   = 5,
    parameter int PC_W     = 32,
    localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_valid_i,
    input  logic [TW-1:0]              alloc_thread_i,
    input  logic [DEST_W-1:0]          alloc_dest_i,
    input  logic [PC_W-1:0]            alloc_pc_i,
    output logic [THREADS-1:0]         alloc_ready_o,
    output logic [IW-1:0]              alloc_id_o,
    input  logic [WB_PORTS-1:0]        wb_valid_i,
    input  logic [WB_PORTS*TW-1:0]     wb_thread_i,
    input  logic [WB_PORTS*IW-1:0]     wb_id_i,
    input  logic [WB_PORTS*DATA_W-1:0] wb_data_i,
    input  logic [WB_PORTS-1:0]        wb_xcpt_i,
    output logic                       rf_we_o,
    output logic [TW-1:0]              rf_thread_o,
    output logic [DEST_W-1:0]          rf_dest_o,
    output logic [DATA_W-1:0]          rf_data_o,
    output logic [IW-1:0]              rf_instr_id_o,
    output logic                       xcpt_valid_o,
    output logic [TW-1:0]              xcpt_thread_o,
    output logic [PC_W-1:0]            xcpt_pc_o,
    output logic [THREADS-1:0]         flush_pipeline_o,
    input  logic [TW-1:0]              byp_thread_i,
    input  logic [IW-1:0]              byp_id_i,
    output logic                       byp_hit_o,
    output logic [DATA_W-1:0]          byp_data_o,
    output logic [THREADS-1:0]         empty_o
);

    logic [ENTRIES-1:0] valid_q [THREADS];
    logic [ENTRIES-1:0] done_q  [THREADS];
    logic [ENTRIES-1:0] xcpt_q  [THREADS];
    logic [DEST_W-1:0]  dest_q  [THREADS][ENTRIES];
    logic [PC_W-1:0]    pc_q    [THREADS][ENTRIES];
    logic [DATA_W-1:0]  data_q  [THREADS][ENTRIES];
    logic [IW-1:0]      head_q  [THREADS];
    logic [IW-1:0]      head_d  [THREADS];
    logic [IW-1:0]      tail_q  [THREADS];
    logic [IW-1:0]      tail_d  [THREADS];
    logic [IW:0]        cnt_q   [THREADS];
    logic [IW:0]        cnt_d   [THREADS];
    logic [TW-1:0]      rr_q, rr_d;

    logic               rf_we_q, rf_we_d;
    logic [TW-1:0]      rf_thread_q, rf_thread_d;
    logic [DEST_W-1:0]  rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0]  rf_data_q, rf_data_d;
    logic [IW-1:0]      rf_id_q, rf_id_d;
    logic               xcpt_valid_q, xcpt_valid_d;
    logic [TW-1:0]      xcpt_thread_q, xcpt_thread_d;
    logic [PC_W-1:0]    xcpt_pc_q, xcpt_pc_d;
    logic [THREADS-1:0] flush_q, flush_d;

    logic [TW-1:0]      wb_thr [WB_PORTS];
    logic [IW-1:0]      wb_idx [WB_PORTS];
    logic [DATA_W-1:0]  wb_dat [WB_PORTS];
    logic [THREADS-1:0] cand, do_ret, do_flush, do_alloc;
    logic               ret_any, ret_x;
    logic [TW-1:0]      ret_t;
    logic [IW-1:0]      ret_h;

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_thr[p] = wb_thread_i[p*TW +: TW];
            wb_idx[p] = wb_id_i[p*IW +: IW];
            wb_dat[p] = wb_data_i[p*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        ret_any = 1'b0;
        ret_t   = '0;
        for (int t = 0; t < THREADS; t++) begin
            cand[t]          = valid_q[t][head_q[t]] & done_q[t][head_q[t]];
            alloc_ready_o[t] = (cnt_q[t] < (IW+1)'(ENTRIES));
            empty_o[t]       = (cnt_q[t] == '0);
        end
        // rr_q holds the last retired thread; threads above it take priority, then wrap around.
        for (int t = THREADS-1; t >= 0; t--) begin
            if (cand[t] && (TW'(t) <= rr_q)) begin
                ret_any = 1'b1;
                ret_t   = TW'(t);
            end
        end
        for (int t = THREADS-1; t >= 0; t--) begin
            if (cand[t] && (TW'(t) > rr_q)) begin
                ret_any = 1'b1;
                ret_t   = TW'(t);
            end
        end
        ret_h = head_q[ret_t];
        ret_x = xcpt_q[ret_t][ret_h];
        rr_d  = ret_any ? ret_t : rr_q;

        for (int t = 0; t < THREADS; t++) begin
            do_ret[t]   = ret_any && (ret_t == TW'(t));
            do_flush[t] = do_ret[t] && ret_x;
            do_alloc[t] = alloc_valid_i && (alloc_thread_i == TW'(t)) && alloc_ready_o[t] && !do_flush[t];
            head_d[t]   = head_q[t] + IW'(do_ret[t]);
            tail_d[t]   = tail_q[t] + IW'(do_alloc[t]);
            cnt_d[t]    = cnt_q[t] + (IW+1)'(do_alloc[t]) - (IW+1)'(do_ret[t]);
            if (do_flush[t]) begin
                head_d[t] = '0;
                tail_d[t] = '0;
                cnt_d[t]  = '0;
            end
        end

        rf_we_d       = ret_any && !ret_x;
        rf_thread_d   = rf_thread_q;
        rf_dest_d     = rf_dest_q;
        rf_data_d     = rf_data_q;
        rf_id_d       = rf_id_q;
        xcpt_valid_d  = ret_any && ret_x;
        xcpt_thread_d = xcpt_thread_q;
        xcpt_pc_d     = xcpt_pc_q;
        flush_d       = do_flush;
        if (ret_any && !ret_x) begin
            rf_thread_d = ret_t;
            rf_dest_d   = dest_q[ret_t][ret_h];
            rf_data_d   = data_q[ret_t][ret_h];
            rf_id_d     = ret_h;
        end
        if (ret_any && ret_x) begin
            xcpt_thread_d = ret_t;
            xcpt_pc_d     = pc_q[ret_t][ret_h];
        end
    end

    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        if (valid_q[byp_thread_i][byp_id_i] && done_q[byp_thread_i][byp_id_i] &&
            !xcpt_q[byp_thread_i][byp_id_i]) begin
            byp_hit_o  = 1'b1;
            byp_data_o = data_q[byp_thread_i][byp_id_i];
        end
`ifdef ROB_WB_BYPASS_EN
        for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (wb_valid_i[p] && !wb_xcpt_i[p] && (wb_thr[p] == byp_thread_i) &&
                (wb_idx[p] == byp_id_i) && valid_q[byp_thread_i][byp_id_i]) begin
                byp_hit_o  = 1'b1;
                byp_data_o = wb_dat[p];
            end
        end
`endif
    end

    assign alloc_id_o       = tail_q[alloc_thread_i];
    assign rf_we_o          = rf_we_q;
    assign rf_thread_o      = rf_thread_q;
    assign rf_dest_o        = rf_dest_q;
    assign rf_data_o        = rf_data_q;
    assign rf_instr_id_o    = rf_id_q;
    assign xcpt_valid_o     = xcpt_valid_q;
    assign xcpt_thread_o    = xcpt_thread_q;
    assign xcpt_pc_o        = xcpt_pc_q;
    assign flush_pipeline_o = flush_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < THREADS; t++) begin
                valid_q[t] <= '0;
                done_q[t]  <= '0;
                xcpt_q[t]  <= '0;
                head_q[t]  <= '0;
                tail_q[t]  <= '0;
                cnt_q[t]   <= '0;
                for (int e = 0; e < ENTRIES; e++) begin
                    dest_q[t][e] <= '0;
                    pc_q[t][e]   <= '0;
                    data_q[t][e] <= '0;
                end
            end
            rr_q          <= '0;
            rf_we_q       <= 1'b0;
            rf_thread_q   <= '0;
            rf_dest_q     <= '0;
            rf_data_q     <= '0;
            rf_id_q       <= '0;
            xcpt_valid_q  <= 1'b0;
            xcpt_thread_q <= '0;
            xcpt_pc_q     <= '0;
            flush_q       <= '0;
        end else begin
            rr_q          <= rr_d;
            rf_we_q       <= rf_we_d;
            rf_thread_q   <= rf_thread_d;
            rf_dest_q     <= rf_dest_d;
            rf_data_q     <= rf_data_d;
            rf_id_q       <= rf_id_d;
            xcpt_valid_q  <= xcpt_valid_d;
            xcpt_thread_q <= xcpt_thread_d;
            xcpt_pc_q     <= xcpt_pc_d;
            flush_q       <= flush_d;
            for (int t = 0; t < THREADS; t++) begin
                head_q[t] <= head_d[t];
                tail_q[t] <= tail_d[t];
                cnt_q[t]  <= cnt_d[t];
                if (do_alloc[t]) begin
                    valid_q[t][tail_q[t]] <= 1'b1;
                    done_q[t][tail_q[t]]  <= 1'b0;
                    xcpt_q[t][tail_q[t]]  <= 1'b0;
                    dest_q[t][tail_q[t]]  <= alloc_dest_i;
                    pc_q[t][tail_q[t]]    <= alloc_pc_i;
                end
            end
            // Descending scan so the lowest-numbered port's write lands last and wins.
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (wb_valid_i[p] && valid_q[wb_thr[p]][wb_idx[p]]) begin
                    done_q[wb_thr[p]][wb_idx[p]] <= 1'b1;
                    xcpt_q[wb_thr[p]][wb_idx[p]] <= wb_xcpt_i[p];
                    data_q[wb_thr[p]][wb_idx[p]] <= wb_dat[p];
                end
            end
            for (int t = 0; t < THREADS; t++) begin
                if (do_ret[t]) begin
                    valid_q[t][head_q[t]] <= 1'b0;
                end
                if (do_flush[t]) begin
                    valid_q[t] <= '0;
                    done_q[t]  <= '0;
                    xcpt_q[t]  <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_mt.sv
`default_nettype none
// tb_reorder_buffer_mt: directed stimulus with a retire scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_reorder_buffer_mt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [1:0]  alloc_thread = '0;
    logic [4:0]  alloc_dest = '0;
    logic [31:0] alloc_pc = '0;
    logic [3:0]  alloc_ready;
    logic [2:0]  alloc_id;
    logic [2:0]  wb_valid = '0;
    logic [5:0]  wb_thread = '0;
    logic [8:0]  wb_id = '0;
    logic [95:0] wb_data = '0;
    logic [2:0]  wb_xcpt = '0;
    logic        rf_we;
    logic [1:0]  rf_thread;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic [2:0]  rf_instr_id;
    logic        xcpt_valid;
    logic [1:0]  xcpt_thread;
    logic [31:0] xcpt_pc;
    logic [3:0]  flush_pipeline;
    logic [1:0]  byp_thread = '0;
    logic [2:0]  byp_id = '0;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic [3:0]  empty;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        x;
        logic [1:0]  t;
        logic [4:0]  dest;
        logic [31:0] val;
        logic [2:0]  id;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    reorder_buffer_mt dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_thread_i(alloc_thread),
        .alloc_dest_i(alloc_dest), .alloc_pc_i(alloc_pc),
        .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
        .wb_valid_i(wb_valid), .wb_thread_i(wb_thread), .wb_id_i(wb_id),
        .wb_data_i(wb_data), .wb_xcpt_i(wb_xcpt),
        .rf_we_o(rf_we), .rf_thread_o(rf_thread), .rf_dest_o(rf_dest),
        .rf_data_o(rf_data), .rf_instr_id_o(rf_instr_id),
        .xcpt_valid_o(xcpt_valid), .xcpt_thread_o(xcpt_thread), .xcpt_pc_o(xcpt_pc),
        .flush_pipeline_o(flush_pipeline),
        .byp_thread_i(byp_thread), .byp_id_i(byp_id),
        .byp_hit_o(byp_hit), .byp_data_o(byp_data),
        .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic x, input logic [1:0] t, input logic [4:0] d,
                        input logic [31:0] v, input logic [2:0] id);
        sb.push_back('{x: x, t: t, dest: d, val: v, id: id});
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] d, input logic [31:0] pc,
                            input logic [2:0] exp_id);
        alloc_valid = 1'b1;
        alloc_thread = t;
        alloc_dest = d;
        alloc_pc = pc;
        #1;
        chk("alloc_id", alloc_id, exp_id);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [1:0] t, input logic [2:0] id,
                          input logic [31:0] d, input logic x);
        wb_valid[p] = 1'b1;
        wb_thread[p*2 +: 2] = t;
        wb_id[p*3 +: 3] = id;
        wb_data[p*32 +: 32] = d;
        wb_xcpt[p] = x;
    endtask

    task automatic wb_go();
        tick();
        wb_valid = '0;
        wb_xcpt = '0;
    endtask

    // Monitor: every retire or exception the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (rf_we || xcpt_valid)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got we=%0b xcpt=%0b thread=%0d dest=%0d expected none",
                         rf_we, xcpt_valid, rf_thread, rf_dest);
            end else begin
                e = sb.pop_front();
                chk("retire_kind", {rf_we, xcpt_valid}, e.x ? 2'b01 : 2'b10);
                if (e.x) begin
                    chk("xcpt_thread", xcpt_thread, e.t);
                    chk("xcpt_pc", xcpt_pc, e.val);
                end else begin
                    chk("rf_thread", rf_thread, e.t);
                    chk("rf_dest", rf_dest, e.dest);
                    chk("rf_data", rf_data, e.val);
                    chk("rf_instr_id", rf_instr_id, e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 4'b1111);
        chk("rst_empty", empty, 4'b1111);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_xcpt_valid", xcpt_valid, 0);
        chk("rst_flush", flush_pipeline, 0);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_rf_data", rf_data, 0);
        tick();

        // Thread 0: out-of-order completion, in-order retire
        do_alloc(2'd0, 5'd3, 32'h10, 3'd0);
        do_alloc(2'd0, 5'd5, 32'h14, 3'd1);
        push(1'b0, 2'd0, 5'd3, 32'hA, 3'd0);
        push(1'b0, 2'd0, 5'd5, 32'hB, 3'd1);
        set_wb(1, 2'd0, 3'd1, 32'hB, 1'b0);
        wb_go();
        set_wb(0, 2'd0, 3'd0, 32'hA, 1'b0);
        wb_go();
        repeat (4) tick();
        chk("t0_empty", empty[0], 1);

        // Round robin from last-retired thread 0, plus a same-entry port collision
        do_alloc(2'd0, 5'd7, 32'h18, 3'd2);
        do_alloc(2'd1, 5'd9, 32'h20, 3'd0);
        push(1'b0, 2'd1, 5'd9, 32'h90, 3'd0);
        push(1'b0, 2'd0, 5'd7, 32'h70, 3'd2);
        set_wb(0, 2'd0, 3'd2, 32'h70, 1'b0);
        set_wb(1, 2'd1, 3'd0, 32'h90, 1'b0);
        set_wb(2, 2'd0, 3'd2, 32'hBAD, 1'b0);
        wb_go();
        repeat (4) tick();

        // Thread 2: fill, dropped overflow, drain and wrap
        for (int i = 0; i < 8; i++) do_alloc(2'd2, 5'(10 + i), 32'h200 + 32'(4 * i), 3'(i));
        chk("full_ready", alloc_ready[2], 0);
        chk("full_empty", empty[2], 0);
        do_alloc(2'd2, 5'd31, 32'h2FF, 3'd0);
        chk("drop_ready", alloc_ready[2], 0);
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 2'd2, 5'(10 + i), 32'h200 + 32'(i), 3'(i));
            set_wb(0, 2'd2, 3'(i), 32'h200 + 32'(i), 1'b0);
            wb_go();
        end
        repeat (4) tick();
        chk("wrap_empty", empty[2], 1);
        chk("wrap_ready", alloc_ready[2], 1);

        // Bypass on a non-head entry that cannot retire yet
        for (int i = 0; i < 5; i++) do_alloc(2'd2, 5'(20 + i), 32'h240 + 32'(i), 3'(i));
        byp_thread = 2'd2;
        byp_id = 3'd4;
        #1;
        chk("byp_pre_hit", byp_hit, 0);
        set_wb(0, 2'd2, 3'd4, 32'h55, 1'b0);
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("byp_same_hit", byp_hit, 1);
        chk("byp_same_data", byp_data, 32'h55);
`else
        chk("byp_same_hit", byp_hit, 0);
        chk("byp_same_data", byp_data, 0);
`endif
        wb_go();
        #1;
        chk("byp_next_hit", byp_hit, 1);
        chk("byp_next_data", byp_data, 32'h55);
        byp_id = 3'd3;
        #1;
        chk("byp_notdone_hit", byp_hit, 0);
        chk("byp_notdone_data", byp_data, 0);

        // Thread 3: excepting head with younger entries, same-cycle alloc discarded
        do_alloc(2'd3, 5'd1, 32'h100, 3'd0);
        do_alloc(2'd3, 5'd2, 32'h104, 3'd1);
        do_alloc(2'd3, 5'd3, 32'h108, 3'd2);
        do_alloc(2'd3, 5'd4, 32'h10C, 3'd3);
        set_wb(1, 2'd3, 3'd1, 32'h11, 1'b0);
        wb_go();
        push(1'b1, 2'd3, 5'd1, 32'h100, 3'd0);
        set_wb(0, 2'd3, 3'd0, 32'hEE, 1'b1);
        wb_go();
        alloc_valid = 1'b1;
        alloc_thread = 2'd3;
        alloc_dest = 5'd9;
        alloc_pc = 32'h200;
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("xcpt_flush", flush_pipeline, 4'b1000);
        chk("xcpt_empty3", empty[3], 1);
        chk("xcpt_tail3", alloc_id, 0);
        chk("xcpt_no_we", rf_we, 0);
        tick();
        chk("flush_pulse_end", flush_pipeline, 0);
        chk("xcpt_valid_end", xcpt_valid, 0);
        repeat (3) tick();

        // Asynchronous reset while a retire is on the outputs
        do_alloc(2'd1, 5'd6, 32'h300, 3'd1);
        set_wb(0, 2'd1, 3'd1, 32'h66, 1'b0);
        wb_go();
        tick();
        chk("pre_rst_we", rf_we, 1);
        chk("pre_rst_data", rf_data, 32'h66);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_data", rf_data, 0);
        chk("async_rst_empty", empty, 4'b1111);
        chk("async_rst_ready", alloc_ready, 4'b1111);
        tick();
        rst_n = 1'b1;
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer_mt.md
# reorder_buffer_mt

Parametrised multi-thread reorder buffer for the writeback stage. It allocates in-order slots per thread at decode and accepts out-of-order completions from a configurable number of writeback ports (ALU, MUL, cache, ...). It retires one instruction per cycle to the register file using round-robin arbitration across threads, and signals exceptions with a per-thread flush. It also serves source-operand bypass lookups from the execute stages.

## Interface
Parameters:
- THREADS, 4, hardware threads per core; TW = max(1, clog2(THREADS))
- ENTRIES, 8, ROB slots per thread (power of two ≥ 2); IW = clog2(ENTRIES)
- WB_PORTS, 3, number of completion ports
- DATA_W, 32, register data width
- DEST_W, 5, RF destination address width
- PC_W, 32, instruction PC width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- alloc_valid  in  1  allocate one slot
- alloc_thread  in  TW  thread of the allocation
- alloc_dest  in  DEST_W  destination register of the instruction
- alloc_pc  in  PC_W  PC of the instruction
- alloc_ready  out  THREADS  per thread: count < ENTRIES
- alloc_id  out  IW  tail index of alloc_thread (the slot granted this cycle)
- wb_valid  in  WB_PORTS  completion valid, one bit per port
- wb_thread  in  WB_PORTS*TW  completion thread, packed per port
- wb_id  in  WB_PORTS*IW  completion slot, packed per port
- wb_data  in  WB_PORTS*DATA_W  result data, packed per port
- wb_xcpt  in  WB_PORTS  completion raised an exception
- rf_we  out  1  registered retire write enable
- rf_thread  out  TW  retiring thread
- rf_dest  out  DEST_W  retiring destination
- rf_data  out  DATA_W  retiring data
- rf_instr_id  out  IW  retiring slot
- xcpt_valid  out  1  registered: the head entry retired with an exception
- xcpt_thread  out  TW  thread of the exception
- xcpt_pc  out  PC_W  PC of the excepting instruction
- flush_pipeline  out  THREADS  one-cycle flush pulse per thread
- byp_thread  in  TW  bypass lookup thread
- byp_id  in  IW  bypass lookup slot
- byp_hit  out  1  combinational: slot is valid and its data is available
- byp_data  out  DATA_W  combinational bypass data
- empty  out  THREADS  per thread: count == 0

## Operation
- Per thread: head, tail (IW bits, wrap modulo ENTRIES) and count (IW+1 bits). Per entry: valid, done, xcpt, dest, pc, data.
- Allocation: if alloc_valid and alloc_ready[alloc_thread], the entry at tail becomes valid with done=0, then tail++ and count++. An allocation to a full thread is dropped silently.
- Writeback: port p writes data, sets done, and sets xcpt = wb_xcpt[p] on entry (thread,id) only if that entry is valid. Writebacks to invalid entries are ignored. If several ports hit the same entry in one cycle, the lowest-numbered port wins.
- Retire arbitration: candidates are threads whose head entry is valid and done. A round-robin pointer starts at (last retired thread + 1) mod THREADS; the first candidate wins.
- Normal retire: rf_* are registered from the head entry with rf_we=1; the entry is invalidated, head++, count--.
- Exception retire: rf_we=0, xcpt_valid=1, xcpt_thread/xcpt_pc are registered, and flush_pipeline[t]=1 for one cycle. All entries of thread t are cleared; head=tail=count=0 at the same edge. An allocation to thread t in the same cycle is discarded.
- Allocation and retire on the same thread in the same cycle: count is unchanged. alloc_ready uses the pre-retire count, so a full thread does not allocate that cycle.
- Bypass: byp_hit=1 and byp_data=entry data when the entry is valid, done and has no exception. Otherwise byp_hit=0 and byp_data=0.

## Timing
- Reset values: rf_we=0, xcpt_valid=0, flush_pipeline=0, rf_* and xcpt_* fields=0, alloc_ready=all ones, empty=all ones, alloc_id=0, round-robin pointer=thread 0, all entries invalid.
- Allocation in cycle 0 makes the entry visible from cycle 1. The earliest legal writeback to it is cycle 1.
- Writeback in cycle N sets done at the end of N. The retire decision is made in N+1, and rf_we/xcpt_valid are high in cycle N+2. Sustained throughput is 1 retire per cycle.
- Reset asserted mid-operation clears all state immediately; registered outputs drop asynchronously.

## Configuration
- ROB_WB_BYPASS_EN defined: the bypass lookup also matches same-cycle wb ports (lowest port first, only if wb_xcpt=0). This gives byp_hit in cycle N for a writeback in cycle N.
- Not defined: bypass sees stored entries only, so hit is visible from cycle N+1.

## Test plan
- Reset with THREADS=4, ENTRIES=8 -> alloc_ready=4'b1111, empty=4'b1111, rf_we=0 on the first cycle after release.
- Thread 0: allocate dest 3 and dest 5 (ids 0,1), writeback id1 data 0xB then id0 data 0xA -> rf_we retires dest 3/0xA, then dest 5/0xB on consecutive cycles, in order.
- Thread 2: allocate 8 entries -> alloc_ready[2]=0; a 9th alloc is dropped. Retire all 8 -> tail wraps to 0 and the next alloc_id=0.
- Threads 0 and 1: heads both done in the same cycle with the pointer at 0 -> thread 1 retires first, then thread 0. Two ports writing the same id in one cycle -> port 0's data retires.
- Thread 3: head writeback with wb_xcpt=1, pc 0x100, plus 3 younger entries -> xcpt_valid=1, xcpt_pc=0x100, flush_pipeline=4'b1000 for 1 cycle, empty[3]=1 next cycle, no rf_we for thread 3.
- Writeback id 4 data 0x55 in cycle N with byp_id=4 -> byp_hit=1 in cycle N if ROB_WB_BYPASS_EN is defined, else first in N+1.
